// File: rtl/regfile_pkg.sv
// Constants and the write-arbitration helper shared by the register file and its arbiter.
package regfile_pkg;

    localparam int CNT_WIDTH      = 16;
    localparam int MAX_RD         = 4;
    localparam int MAX_WR         = 4;
    localparam int MIN_DEPTH      = 2;
    localparam int MAX_ADDR_WIDTH = 16;

    // A later write port loses to any enabled earlier port that targets the same entry.
    function automatic logic wr_blocked(
        input logic                      earlier_en,
        input logic [MAX_ADDR_WIDTH-1:0] earlier_addr,
        input logic [MAX_ADDR_WIDTH-1:0] addr
    );
        return earlier_en && (earlier_addr == addr);
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter: lowest-index port wins each address; writes to a hardwired
// zero entry are silently discarded (neither accepted nor counted as dropped).
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int NUM_WR     = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 0
) (
    input  logic [NUM_WR-1:0]            i_wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wad,
    output logic [NUM_WR-1:0]            o_accept,
    output logic [NUM_WR-1:0]            o_drop
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : gen_port
            logic w_blocked;
            logic w_zero;

            always_comb begin
                w_blocked = 1'b0;
                for (int k = 0; k < gi; k++) begin
                    w_blocked = w_blocked | wr_blocked(
                        i_wen[k],
                        MAX_ADDR_WIDTH'(i_wad[k*ADDR_WIDTH +: ADDR_WIDTH]),
                        MAX_ADDR_WIDTH'(i_wad[gi*ADDR_WIDTH +: ADDR_WIDTH]));
                end
            end

            assign w_zero       = (ZERO_REG != 0) && (i_wad[gi*ADDR_WIDTH +: ADDR_WIDTH] == '0);
            assign o_accept[gi] = i_wen[gi] && !w_zero && !w_blocked;
            assign o_drop[gi]   = i_wen[gi] && !w_zero && w_blocked;
        end
    endgenerate

endmodule

// File: rtl/multiport_regfile.sv
// Multi-port register file: one-cycle registered reads, optional write-to-read
// forwarding, optional hardwired-zero entry 0, saturating dropped-write counter.
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_WR-1:0]            wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wad,
    input  logic [NUM_WR*DATA_WIDTH-1:0] din,
    input  logic [NUM_RD-1:0]            ren,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rad,
    output logic [NUM_RD*DATA_WIDTH-1:0] dout,
    output logic [NUM_RD-1:0]            rvalid,
    output logic [NUM_WR-1:0]            wr_conflict,
    output logic [NUM_RD-1:0]            raw_hit,
    output logic [CNT_WIDTH-1:0]         conflict_cnt
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [NUM_WR-1:0]     w_accept;
    logic [NUM_WR-1:0]     w_drop;
    logic [NUM_WR-1:0]     r_wr_conflict;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [2:0]            w_drop_num;
    logic [CNT_WIDTH:0]    w_cnt_sum;

    regfile_wr_arb #(
        .NUM_WR     (NUM_WR),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_wr_arb (
        .i_wen    (wen),
        .i_wad    (wad),
        .o_accept (w_accept),
        .o_drop   (w_drop)
    );

    // Accepted writes always target distinct entries, so loop order does not matter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (w_accept[i]) begin
                    r_mem[wad[i*ADDR_WIDTH +: ADDR_WIDTH]] <= din[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            w_drop_num = w_drop_num + 3'(w_drop[i]);
        end
    end

    assign w_cnt_sum = {1'b0, r_cnt} + (CNT_WIDTH+1)'(w_drop_num);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt         <= '0;
            r_wr_conflict <= '0;
        end else begin
            r_cnt         <= w_cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_cnt_sum[CNT_WIDTH-1:0];
            r_wr_conflict <= w_drop;
        end
    end

    assign wr_conflict  = r_wr_conflict;
    assign conflict_cnt = r_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : gen_rd
            logic [ADDR_WIDTH-1:0] w_rad;
            logic                  w_hit;
            logic [DATA_WIDTH-1:0] w_fwd;
            logic [DATA_WIDTH-1:0] w_rd_data;
            logic [DATA_WIDTH-1:0] r_dout;
            logic                  r_rvalid;
            logic                  r_raw_hit;

            assign w_rad = rad[gi*ADDR_WIDTH +: ADDR_WIDTH];

            // At most one accepted write can match, so the last match is the only match.
            always_comb begin
                w_hit = 1'b0;
                w_fwd = '0;
                for (int i = 0; i < NUM_WR; i++) begin
                    if (w_accept[i] && (wad[i*ADDR_WIDTH +: ADDR_WIDTH] == w_rad)) begin
                        w_hit = 1'b1;
                        w_fwd = din[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            always_comb begin
                if ((ZERO_REG != 0) && (w_rad == '0)) begin
                    w_rd_data = '0;
                end else if ((BYPASS != 0) && w_hit) begin
                    w_rd_data = w_fwd;
                end else begin
                    w_rd_data = r_mem[w_rad];
                end
            end

            always_ff @(posedge clk) begin
                if (!resetn || !ren[gi]) begin
                    r_dout    <= '0;
                    r_rvalid  <= 1'b0;
                    r_raw_hit <= 1'b0;
                end else begin
                    r_dout    <= w_rd_data;
                    r_rvalid  <= 1'b1;
                    r_raw_hit <= w_hit;
                end
            end

            assign dout[gi*DATA_WIDTH +: DATA_WIDTH] = r_dout;
            assign rvalid[gi]                        = r_rvalid;
            assign raw_hit[gi]                       = r_raw_hit;
        end
    endgenerate

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench: three register-file variants (bypass, no-bypass, zero-reg) share one stimulus stream.
module tb_multiport_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic [1:0]    wen;
    logic [2*AW-1:0] wad;
    logic [2*DW-1:0] din;
    logic [1:0]    ren;
    logic [2*AW-1:0] rad;

    logic [2*DW-1:0] dout_a, dout_n, dout_z;
    logic [1:0]      rvalid_a, rvalid_n, rvalid_z;
    logic [1:0]      wrc_a, wrc_n, wrc_z;
    logic [1:0]      raw_a, raw_n, raw_z;
    logic [15:0]     cnt_a, cnt_n, cnt_z;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multiport_regfile #(.BYPASS(1), .ZERO_REG(0)) u_dut_a (
        .clk(clk), .resetn(resetn), .wen(wen), .wad(wad), .din(din), .ren(ren), .rad(rad),
        .dout(dout_a), .rvalid(rvalid_a), .wr_conflict(wrc_a), .raw_hit(raw_a), .conflict_cnt(cnt_a));

    multiport_regfile #(.BYPASS(0), .ZERO_REG(0)) u_dut_n (
        .clk(clk), .resetn(resetn), .wen(wen), .wad(wad), .din(din), .ren(ren), .rad(rad),
        .dout(dout_n), .rvalid(rvalid_n), .wr_conflict(wrc_n), .raw_hit(raw_n), .conflict_cnt(cnt_n));

    multiport_regfile #(.BYPASS(1), .ZERO_REG(1)) u_dut_z (
        .clk(clk), .resetn(resetn), .wen(wen), .wad(wad), .din(din), .ren(ren), .rad(rad),
        .dout(dout_z), .rvalid(rvalid_z), .wr_conflict(wrc_z), .raw_hit(raw_z), .conflict_cnt(cnt_z));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = '0; wad = '0; din = '0; ren = '0; rad = '0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen[p] = 1'b1;
        wad[p*AW +: AW] = a;
        din[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        ren[p] = 1'b1;
        rad[p*AW +: AW] = a;
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        tick();
        tick();
        check_val("rst_dout",   64'(dout_a), 64'h0);
        check_val("rst_rvalid", 64'(rvalid_a), 64'h0);
        check_val("rst_cnt",    64'(cnt_a), 64'h0);
        check_val("rst_wrc",    64'(wrc_a), 64'h0);

        // First read after reset: entry 5 is zero, rvalid on port 0 only
        resetn = 1'b1;
        idle(); set_rd(0, 5'd5);
        tick();
        check_val("rd5_dout0",  64'(dout_a[31:0]), 64'h0);
        check_val("rd5_rvalid", 64'(rvalid_a), 64'h1);

        idle(); set_wr(0, 5'd3, 32'hA5A5_0001);
        tick();
        check_val("noread_rvalid", 64'(rvalid_a), 64'h0);
        check_val("noread_dout",   64'(dout_a), 64'h0);

        idle(); set_rd(0, 5'd3); set_rd(1, 5'd3);
        tick();
        check_val("dual_rd3", 64'(dout_a), {32'hA5A5_0001, 32'hA5A5_0001});
        check_val("dual_rd3_rvalid", 64'(rvalid_a), 64'h3);
        check_val("dual_rd3_raw", 64'(raw_a), 64'h0);
        check_val("dual_rd3_wrc", 64'(wrc_a), 64'h0);

        // Write-write collision on entry 7: port 0 wins
        idle(); set_wr(0, 5'd7, 32'h11); set_wr(1, 5'd7, 32'h22);
        tick();
        check_val("ww_wrc", 64'(wrc_a), 64'h2);
        check_val("ww_cnt", 64'(cnt_a), 64'h1);
        check_val("ww_cnt_z", 64'(cnt_z), 64'h1);

        idle(); set_rd(0, 5'd7);
        tick();
        check_val("ww_rd7", 64'(dout_a[31:0]), 64'h11);
        check_val("ww_wrc_clear", 64'(wrc_a), 64'h0);

        // Same-cycle write/read of entry 9
        idle(); set_wr(0, 5'd9, 32'h55); set_rd(1, 5'd9);
        tick();
        check_val("byp_dout1",  64'(dout_a[63:32]), 64'h55);
        check_val("byp_raw",    64'(raw_a), 64'h2);
        check_val("nbyp_dout1", 64'(dout_n[63:32]), 64'h0);
        check_val("nbyp_raw",   64'(raw_n), 64'h2);

        idle(); set_rd(0, 5'd9);
        tick();
        check_val("nbyp_rd9", 64'(dout_n[31:0]), 64'h55);

        // Distinct-address writes both commit
        idle(); set_wr(0, 5'd1, 32'h1111); set_wr(1, 5'd2, 32'h2222);
        tick();
        check_val("dist_wrc", 64'(wrc_a), 64'h0);
        check_val("dist_cnt", 64'(cnt_a), 64'h1);

        idle(); set_rd(0, 5'd1); set_rd(1, 5'd2);
        tick();
        check_val("dist_rd", 64'(dout_a), {32'h2222, 32'h1111});

        // Entry 0 behaviour with and without the hardwired zero
        idle(); set_wr(0, 5'd0, 32'hFF); set_rd(1, 5'd0);
        tick();
        check_val("z_dout1", 64'(dout_z[63:32]), 64'h0);
        check_val("z_raw",   64'(raw_z), 64'h0);
        check_val("a_dout1_0", 64'(dout_a[63:32]), 64'hFF);

        idle(); set_wr(0, 5'd0, 32'hAB); set_wr(1, 5'd0, 32'hCD);
        tick();
        check_val("z_wrc", 64'(wrc_z), 64'h0);
        check_val("z_cnt", 64'(cnt_z), 64'h1);
        check_val("a_wrc0", 64'(wrc_a), 64'h2);
        check_val("a_cnt2", 64'(cnt_a), 64'h2);

        idle(); set_rd(0, 5'd0);
        tick();
        check_val("z_rd0", 64'(dout_z[31:0]), 64'h0);
        check_val("a_rd0", 64'(dout_a[31:0]), 64'hAB);

        // Saturate the counter with 65540 drops
        idle(); set_wr(0, 5'd4, 32'h1); set_wr(1, 5'd4, 32'h2);
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        #1;
        check_val("sat_cnt_a", 64'(cnt_a), 64'hFFFF);
        check_val("sat_cnt_z", 64'(cnt_z), 64'hFFFF);
        tick();
        check_val("sat_hold", 64'(cnt_a), 64'hFFFF);

        // Reset in the middle of traffic
        idle(); set_wr(0, 5'd5, 32'h77); set_rd(0, 5'd3); set_rd(1, 5'd4);
        resetn = 1'b0;
        tick();
        check_val("mrst_dout",   64'(dout_a), 64'h0);
        check_val("mrst_rvalid", 64'(rvalid_a), 64'h0);
        check_val("mrst_cnt",    64'(cnt_a), 64'h0);
        check_val("mrst_wrc",    64'(wrc_a), 64'h0);

        resetn = 1'b1;
        idle(); set_rd(0, 5'd3); set_rd(1, 5'd5);
        tick();
        check_val("post_rst_rd", 64'(dout_a), 64'h0);
        check_val("post_rst_rvalid", 64'(rvalid_a), 64'h3);

        idle(); set_rd(0, 5'd7); set_rd(1, 5'd4);
        tick();
        check_val("post_rst_rd2", 64'(dout_a), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bits per register entry.
REQ-002 Parameter DEPTH, default 32, number of entries; power of two, >=2.
REQ-003 Parameter NUM_RD, default 2, number of read ports, 1..4.
REQ-004 Parameter NUM_WR, default 2, number of write ports, 1..4.
REQ-005 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = read returns pre-write contents.
REQ-006 Parameter ZERO_REG, default 0, 1 = entry 0 reads as zero and ignores writes.
REQ-007 Derived ADDR_WIDTH = $clog2(DEPTH); CNT_WIDTH = 16.
REQ-008 clk  input  1  clock; all state updates on its rising edge.
REQ-009 resetn  input  1  reset, synchronous, active-low.
REQ-010 wen  input  NUM_WR  per-port write enable.
REQ-011 wad  input  NUM_WR*ADDR_WIDTH  per-port write address, port i at slice i.
REQ-012 din  input  NUM_WR*DATA_WIDTH  per-port write data.
REQ-013 ren  input  NUM_RD  per-port read enable.
REQ-014 rad  input  NUM_RD*ADDR_WIDTH  per-port read address.
REQ-015 dout  output  NUM_RD*DATA_WIDTH  registered per-port read data.
REQ-016 rvalid  output  NUM_RD  registered; high the cycle after an accepted read.
REQ-017 wr_conflict  output  NUM_WR  registered; bit i high when port i's write was dropped.
REQ-018 raw_hit  output  NUM_RD  registered; bit j high when read j matched a same-cycle accepted write.
REQ-019 conflict_cnt  output  CNT_WIDTH  saturating count of dropped writes.

Function
REQ-020 Read latency SHALL be exactly one cycle: ren[j] at edge N -> dout[j]/rvalid[j] valid after edge N.
REQ-021 ren[j]=0 SHALL drive dout[j]=0, rvalid[j]=0, raw_hit[j]=0 next cycle.
REQ-022 Multiple read ports at the same address SHALL all return the entry; no collision.
REQ-023 Write-write: when several enabled ports share an address, lowest-index port SHALL be accepted; each higher-index one is dropped and its wr_conflict bit set for one cycle.
REQ-024 conflict_cnt SHALL add the number of dropped writes each cycle, saturating at 2^CNT_WIDTH-1, never wrapping.
REQ-025 Accepted writes SHALL update the array at the clock edge; distinct-address writes all commit in the same cycle.
REQ-026 BYPASS=1 and read address equals an accepted write address: dout SHALL return that write's din; raw_hit set.
REQ-027 BYPASS=0 and same match: dout SHALL return pre-write contents; raw_hit still set.
REQ-028 ZERO_REG=1: writes to address 0 SHALL be discarded (not counted as conflicts, no raw_hit), reads of 0 return 0.
REQ-029 Addresses >= DEPTH are unreachable by construction (DEPTH power of two).

Reset
REQ-030 resetn=0 at an edge SHALL clear all array entries, dout, rvalid, wr_conflict, raw_hit, conflict_cnt to 0.
REQ-031 During reset, wen/ren SHALL be ignored; no write commits in a reset cycle.
REQ-032 Reset asserted mid-traffic SHALL discard in-flight read results; first post-reset read returns 0 for any address.
REQ-033 Array SHALL also initialise to 0 at time zero for simulation.

Structure
REQ-034 Shared package regfile_pkg SHALL hold CNT_WIDTH, port-count limits, and the write-arbitration helper function.
REQ-035 One sub-module regfile_wr_arb SHALL compute per-port accept/drop from wen/wad (combinational, NUM_WR parameter).
REQ-036 Array, bypass mux, output registers and counter SHALL live in multiport_regfile.

Verification
REQ-037 Reset then ren[0]=1 rad=5 -> next cycle dout[0]=0, rvalid[0]=1.
REQ-038 wen[0]=1 wad=3 din=0xA5A5_0001; next cycle ren[0]=ren[1]=1 rad=3 -> both dout=0xA5A5_0001, no flags.
REQ-039 wen[0]=wen[1]=1 wad=7, din0=0x11, din1=0x22 -> wr_conflict=2'b10, conflict_cnt=1; later read of 7 returns 0x11.
REQ-040 BYPASS=1: wen[0]=1 wad=9 din=0x55 with ren[1]=1 rad=9 same cycle -> dout[1]=0x55, raw_hit[1]=1; BYPASS=0 -> dout[1]=0 (prior value).
REQ-041 ZERO_REG=1: write 0xFF to address 0, read 0 -> dout=0, no raw_hit, counter unchanged.
REQ-042 Force 65540 dropped writes -> conflict_cnt holds 0xFFFF; assert resetn=0 one cycle -> counter and all entries 0.
